// File: rtl/scope_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scope_stream_pkg
// Description : Shared constants, types and tag decode helper for the scope
//               stream combiner/splitter family.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : DEST_FIELD_WIDTH, MAX_SCOPE_CHANNELS, CH_INDEX_WIDTH,
//               chan_sel_t {in_range, index}, tag_to_channel()
// ============================================================================
package scope_stream_pkg;

  localparam int DEST_FIELD_WIDTH   = 8;
  localparam int MAX_SCOPE_CHANNELS = 6;
  localparam int CH_INDEX_WIDTH     = 3;

  typedef struct packed {
    logic                      in_range;
    logic [CH_INDEX_WIDTH-1:0] index;
  } chan_sel_t;

  // Maps a tag to a channel index relative to base. A ninth bit catches tags
  // below base (borrow out), which are out of range like tags past n_ch-1.
  function automatic chan_sel_t tag_to_channel(
    input logic [DEST_FIELD_WIDTH-1:0] tag,
    input logic [DEST_FIELD_WIDTH-1:0] base,
    input logic [CH_INDEX_WIDTH:0]     n_ch
  );
    chan_sel_t                 sel;
    logic [DEST_FIELD_WIDTH:0] diff;
    diff         = {1'b0, tag} - {1'b0, base};
    sel.in_range = ~diff[DEST_FIELD_WIDTH] &&
                   (diff < {{(DEST_FIELD_WIDTH-CH_INDEX_WIDTH){1'b0}}, n_ch});
    sel.index    = diff[CH_INDEX_WIDTH-1:0];
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scope_splitter_stage.sv
`default_nettype none
// ============================================================================
// Module      : scope_splitter_stage
// Description : One-entry holding register for a single splitter output
//               channel. Loads on i_load, drains on o_valid & i_ready; a
//               same-cycle load and drain keeps the channel full.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk, rst_n        clock, async active-low reset
//               i_load            accept a new beat this cycle
//               i_data/dest/user/last  beat fields to capture
//               i_ready           downstream ready
//               o_valid/data/dest/user/last  registered channel output
// ============================================================================
module scope_splitter_stage
  import scope_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic [DEST_FIELD_WIDTH-1:0] i_dest,
  input  logic [7:0]                  i_user,
  input  logic                        i_last,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [DEST_FIELD_WIDTH-1:0] o_dest,
  output logic [7:0]                  o_user,
  output logic                        o_last
);

  logic                        r_valid;
  logic [DATA_WIDTH-1:0]       r_data;
  logic [DEST_FIELD_WIDTH-1:0] r_dest;
  logic [7:0]                  r_user;
  logic                        r_last;

  // Payload only changes on a load, so it stays stable while a beat waits
  // for its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_dest  <= '0;
      r_user  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_dest  <= i_dest;
      r_user  <= i_user;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dest  = r_dest;
  assign o_user  = r_user;
  assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/scope_splitter.sv
`default_nettype none
// ============================================================================
// Module      : scope_splitter
// Description : Routes a tagged combined stream to up to six output streams,
//               stripping the tag. Out-of-range tags are accepted, discarded
//               and counted in a saturating drop counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk, rst_n          clock, async active-low reset
//               i_in_data/dest/user/last/valid, o_in_ready   combined input
//               o_out_valid[k], o_out_data[k*ODW+:ODW], o_out_dest[k*8+:8],
//               o_out_user[k*8+:8], o_out_last[k], i_out_ready[k]
//                                   channel k+1 output stream
//               o_drop_count        saturating count of discarded beats
// ============================================================================
module scope_splitter
  import scope_stream_pkg::*;
#(
  parameter int    INPUT_DATA_WIDTH  = 32,
  parameter int    OUTPUT_DATA_WIDTH = 16,
  parameter string MSB_DEST_SUPPORT  = "TRUE",
  parameter int    N_CHANNELS        = 6,
  parameter int    DEST_BASE         = 0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [INPUT_DATA_WIDTH-1:0]                     i_in_data,
  input  logic [DEST_FIELD_WIDTH-1:0]                     i_in_dest,
  input  logic [7:0]                                      i_in_user,
  input  logic                                            i_in_last,
  input  logic                                            i_in_valid,
  output logic                                            o_in_ready,
  output logic [MAX_SCOPE_CHANNELS-1:0]                   o_out_valid,
  output logic [MAX_SCOPE_CHANNELS*OUTPUT_DATA_WIDTH-1:0] o_out_data,
  output logic [MAX_SCOPE_CHANNELS*DEST_FIELD_WIDTH-1:0]  o_out_dest,
  output logic [MAX_SCOPE_CHANNELS*8-1:0]                 o_out_user,
  output logic [MAX_SCOPE_CHANNELS-1:0]                   o_out_last,
  input  logic [MAX_SCOPE_CHANNELS-1:0]                   i_out_ready,
  output logic [15:0]                                     o_drop_count
);

  localparam int ODW = OUTPUT_DATA_WIDTH;
  localparam int IDW = INPUT_DATA_WIDTH;
  localparam bit c_use_msb_tag = (MSB_DEST_SUPPORT == "TRUE");
  localparam int c_pad_w       = (1 << CH_INDEX_WIDTH) - MAX_SCOPE_CHANNELS;
  localparam logic [CH_INDEX_WIDTH:0]     c_n_ch = N_CHANNELS[CH_INDEX_WIDTH:0];
  localparam logic [DEST_FIELD_WIDTH-1:0] c_base = DEST_BASE[DEST_FIELD_WIDTH-1:0];

  generate
    if (N_CHANNELS < 1 || N_CHANNELS > MAX_SCOPE_CHANNELS) begin : g_bad_channels
      $error("scope_splitter: N_CHANNELS must be in 1..6");
    end
    if (c_use_msb_tag ? (ODW > IDW - DEST_FIELD_WIDTH) : (ODW > IDW)) begin : g_bad_width
      $error("scope_splitter: OUTPUT_DATA_WIDTH too wide for INPUT_DATA_WIDTH");
    end
  endgenerate

  // Async assert, synchronous release of the internal reset.
  logic [1:0] r_rst_pipe;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_pipe <= 2'b00;
    else        r_rst_pipe <= {r_rst_pipe[0], 1'b1};
  end

  assign w_rst_n = r_rst_pipe[1];

  logic [DEST_FIELD_WIDTH-1:0] w_tag;

  generate
    if (c_use_msb_tag) begin : g_tag_msb
      assign w_tag = i_in_data[IDW-1 -: DEST_FIELD_WIDTH];
    end else begin : g_tag_side
      assign w_tag = i_in_dest;
    end
  endgenerate

  chan_sel_t                       w_sel;
  logic [(1<<CH_INDEX_WIDTH)-1:0]  w_hv_pad;
  logic [(1<<CH_INDEX_WIDTH)-1:0]  w_rdy_pad;
  logic                            w_accept;
  logic                            w_drop;
  logic                            w_unused_bits;

  assign w_sel     = tag_to_channel(w_tag, c_base, c_n_ch);
  // Padded to the full index range so any decoded index is a legal select.
  assign w_hv_pad  = {{c_pad_w{1'b0}}, o_out_valid};
  assign w_rdy_pad = {{c_pad_w{1'b0}}, i_out_ready};

  // Ready looks only at the channel the presented beat targets; discarded
  // beats are always taken.
  assign o_in_ready = w_sel.in_range ?
                      (~w_hv_pad[w_sel.index] | w_rdy_pad[w_sel.index]) : 1'b1;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_drop     = w_accept & ~w_sel.in_range;

  // Upper data bits, the unused tag source and idle-channel readies.
  assign w_unused_bits = ^{i_in_data, i_in_dest, i_out_ready};

  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_drop_count <= 16'h0000;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_drop_count = r_drop_count;

  generate
    for (genvar k = 0; k < MAX_SCOPE_CHANNELS; k++) begin : g_chan
      if (k < N_CHANNELS) begin : g_active
        logic w_load;
        assign w_load = w_accept & w_sel.in_range &
                        (w_sel.index == CH_INDEX_WIDTH'(k));

        scope_splitter_stage #(
          .DATA_WIDTH (ODW)
        ) u_stage (
          .clk     (clk),
          .rst_n   (w_rst_n),
          .i_load  (w_load),
          .i_data  (i_in_data[ODW-1:0]),
          .i_dest  (w_tag),
          .i_user  (i_in_user),
          .i_last  (i_in_last),
          .i_ready (i_out_ready[k]),
          .o_valid (o_out_valid[k]),
          .o_data  (o_out_data[k*ODW +: ODW]),
          .o_dest  (o_out_dest[k*DEST_FIELD_WIDTH +: DEST_FIELD_WIDTH]),
          .o_user  (o_out_user[k*8 +: 8]),
          .o_last  (o_out_last[k])
        );
      end else begin : g_idle
        assign o_out_valid[k]                                      = 1'b0;
        assign o_out_data[k*ODW +: ODW]                            = '0;
        assign o_out_dest[k*DEST_FIELD_WIDTH +: DEST_FIELD_WIDTH]  = '0;
        assign o_out_user[k*8 +: 8]                                = '0;
        assign o_out_last[k]                                       = 1'b0;
      end
    end
  endgenerate

endmodule
`default_nettype wire
